fio_stream_ctrl: RTL

//  Peripheral-bus controller that sequences the file-I/O byte stream between the MSP430 core and the host.
//  CPU writes bytes into a TX FIFO; a drain FSM presents them to the host on a valid/ready channel.

---
 rtl/fio_stream_ctrl_pkg.sv | 33 +++
 rtl/fio_fifo.sv | 63 ++++++
 rtl/fio_stream_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fio_stream_ctrl_pkg.sv
// Shared definitions for the file-I/O stream controller: register word
// indices within the 4-register window, CTRL/STATUS bit positions, TX FSM
// state encoding and the CTRL reset value.
package fio_stream_ctrl_pkg;

  // Word index of each register (byte offset >> 1)
  localparam int REG_STATUS = 0;
  localparam int REG_DATA   = 1;
  localparam int REG_CTRL   = 2;
  localparam int REG_LEVEL  = 3;

  // STATUS bits
  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_TX_OVF    = 3;

  // CTRL bits
  localparam int CT_TX_EN    = 0;
  localparam int CT_RX_EN    = 1;
  localparam int CT_TX_FLUSH = 2;
  localparam int CT_RX_FLUSH = 3;
  localparam int CT_RX_IE    = 4;
  localparam int CT_TX_IE    = 5;

  localparam logic [15:0] CTRL_RST = 16'h0003;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/fio_fifo.sv
// Purpose: generic synchronous FIFO used for both the TX and RX byte queues.
// Latency: push visible at dout/count after one clk edge; dout shows the head combinationally.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush wins over push/pop.
// Ports: clk, rst (async active-high), push/pop/flush strobes, din/dout data,
//        full/empty flags, count (occupancy, DEPTH_LOG2+1 bits).
module fio_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_pop;
  logic                  do_push;

  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Count never exceeds DEPTH, so its MSB alone marks "full".
  assign full  = count_q[DEPTH_LOG2];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fio_stream_ctrl.sv
// Purpose: MSP430 peripheral that buffers the file-I/O byte stream between CPU and host
//          (TX FIFO + drain FSM toward host, RX FIFO from host, STATUS/DATA/CTRL/LEVEL registers).
// Latency: per_dout combinational; CPU TX byte reaches host_tx_valid 2 edges after the write; irq +1 cycle.
// Backpressure: host_tx_ready stalls the drain FSM; host_rx_ready drops when RX is full or rx_en=0.
// Ports: mclk/puc_rst, openMSP430 peripheral bus (per_*), host TX and RX valid/ready channels,
//        irq (only when FIO_IRQ_EN is defined; otherwise CTRL[5:4] read 0).
module fio_stream_ctrl
  import fio_stream_ctrl_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR     = 15'h00c8,
  parameter int          DEC_WD        = 3,
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter int          RX_DEPTH_LOG2 = 3
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic        host_rx_ready
`ifdef FIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [RX_DEPTH_LOG2:0] RX_ONE = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};

  // ---------------- address decode ----------------
  logic              reg_sel;
  logic [DEC_WD-2:0] reg_idx;
  logic              reg_rd;
  logic              reg_wr_lo;
  logic              sel_status, sel_data, sel_ctrl;
  logic              status_wr, data_wr, ctrl_wr, data_rd;

  // per_addr is a word address; BASE_ADDR is a byte address.
  assign reg_sel    = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx    = per_addr[DEC_WD-2:0];
  assign reg_rd     = reg_sel & (per_we == 2'b00);
  assign reg_wr_lo  = reg_sel & per_we[0];
  assign sel_status = (int'(reg_idx) == REG_STATUS);
  assign sel_data   = (int'(reg_idx) == REG_DATA);
  assign sel_ctrl   = (int'(reg_idx) == REG_CTRL);
  assign status_wr  = reg_wr_lo & sel_status;
  assign data_wr    = reg_wr_lo & sel_data;
  assign ctrl_wr    = reg_wr_lo & sel_ctrl;
  assign data_rd    = reg_rd & sel_data;

  // All register fields live in the low byte.
  logic unused_din_hi;
  assign unused_din_hi = &{1'b0, per_din[15:8]};

  // ---------------- CTRL ----------------
  logic tx_en, rx_en, rx_en_nxt, rx_ie, tx_ie;
  logic tx_flush, rx_flush;

  // Flush bits are single-cycle strobes taken straight from the write.
  assign tx_flush  = ctrl_wr & per_din[CT_TX_FLUSH];
  assign rx_flush  = ctrl_wr & per_din[CT_RX_FLUSH];
  assign rx_en_nxt = ctrl_wr ? per_din[CT_RX_EN] : rx_en;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      tx_en <= CTRL_RST[CT_TX_EN];
      rx_en <= CTRL_RST[CT_RX_EN];
    end else begin
      rx_en <= rx_en_nxt;
      if (ctrl_wr) tx_en <= per_din[CT_TX_EN];
    end
  end

  // ---------------- TX path ----------------
  logic                   tx_full, tx_empty, tx_load, tx_can_load, tx_drop, tx_ovf, tx_idle;
  logic [7:0]             tx_dout;
  logic [TX_DEPTH_LOG2:0] tx_count;
  tx_state_e              state, state_nxt;

  fio_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk   (mclk),
    .rst   (puc_rst),
    .push  (data_wr),
    .pop   (tx_load),
    .flush (tx_flush),
    .din   (per_din[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // No reload during a flush so that the flush leaves nothing behind.
  assign tx_can_load = tx_en & ~tx_empty & ~tx_flush;
  assign tx_drop     = data_wr & tx_full & ~tx_load;

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (tx_can_load) begin
          tx_load   = 1'b1;
          state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        // The byte in flight always completes; only the next load is gated.
        if (host_tx_ready) begin
          if (tx_can_load) tx_load = 1'b1;
          else             state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state        <= TX_IDLE;
      host_tx_data <= 8'h00;
      tx_ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tx_load) host_tx_data <= tx_dout;
      if (tx_drop) tx_ovf <= 1'b1;
      else if (status_wr && per_din[ST_TX_OVF]) tx_ovf <= 1'b0;
    end
  end

  assign host_tx_valid = (state == TX_SEND);
  assign tx_idle       = tx_empty & (state == TX_IDLE);

  // ---------------- RX path ----------------
  logic                   rx_full, rx_empty, rx_push, rx_pop, rx_full_nxt;
  logic [7:0]             rx_dout;
  logic [RX_DEPTH_LOG2:0] rx_count, rx_count_nxt;

  assign rx_push = host_rx_valid & host_rx_ready;
  assign rx_pop  = data_rd & ~rx_empty;

  fio_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk   (mclk),
    .rst   (puc_rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (host_rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Ready is registered, so it is derived from where the count is heading.
  always_comb begin
    rx_count_nxt = rx_count;
    if (rx_flush)                 rx_count_nxt = '0;
    else if (rx_push && !rx_pop)  rx_count_nxt = rx_count + RX_ONE;
    else if (rx_pop && !rx_push)  rx_count_nxt = rx_count - RX_ONE;
  end
  assign rx_full_nxt = rx_count_nxt[RX_DEPTH_LOG2];

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) host_rx_ready <= 1'b0;
    else         host_rx_ready <= rx_en_nxt & ~rx_full_nxt;
  end

  // ---------------- interrupt ----------------
`ifdef FIO_IRQ_EN
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      rx_ie <= CTRL_RST[CT_RX_IE];
      tx_ie <= CTRL_RST[CT_TX_IE];
      irq   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= per_din[CT_RX_IE];
        tx_ie <= per_din[CT_TX_IE];
      end
      irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_idle);
    end
  end
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
`endif

  // ---------------- read mux ----------------
  logic [7:0] tx_lvl, rx_lvl;
  assign tx_lvl = 8'(tx_count);
  assign rx_lvl = 8'(rx_count);

  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      if (sel_status)    per_dout = {12'h000, tx_ovf, tx_idle, tx_full, ~rx_empty};
      else if (sel_data) per_dout = {8'h00, rx_empty ? 8'h00 : rx_dout};
      else if (sel_ctrl) per_dout = {10'h000, tx_ie, rx_ie, 2'b00, rx_en, tx_en};
      else               per_dout = {rx_lvl, tx_lvl};
    end
  end

endmodule
